// File: rtl/mem_pkg.sv
// Shared types for the MEM stage.
//   mem_size_e  : access size encoding carried on in_size
//   mem_state_e : MEM stage FSM states
//   aligned()   : natural-alignment check on the low address bits
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } mem_state_e;

  // Only the low three address bits matter for dword-granular alignment.
  function automatic logic aligned(logic [2:0] addr, mem_size_e size);
    logic ok;
    ok = 1'b1;
    unique case (size)
      SZ_B: ok = 1'b1;
      SZ_H: ok = (addr[0] == 1'b0);
      SZ_W: ok = (addr[1:0] == 2'b00);
      SZ_D: ok = (addr[2:0] == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic for the MEM stage.
//   rdata_i     : dword read from DataMemory
//   wdata_i     : store data, right-justified
//   size_i      : access size (mem_size_e encoding)
//   offset_i    : byte offset within the dword (addr[2:0])
//   sign_ext_i  : sign-extend loads when set
//   load_data_o : selected lane, extended to 64 bits
//   merged_o    : rdata_i with the selected lane replaced by the low bits of wdata_i
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [63:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [2:0]  offset_i,
  input  logic        sign_ext_i,
  output logic [63:0] load_data_o,
  output logic [63:0] merged_o
);

  logic [5:0]  shamt;
  logic [63:0] lane_mask;
  logic [63:0] shifted;
  logic        sign_bit;

  always_comb begin
    shamt     = '0;
    lane_mask = '1;
    sign_bit  = 1'b0;
    shifted   = '0;

    // Lane position ignores offset bits below the access size.
    unique case (mem_size_e'(size_i))
      SZ_B: begin
        shamt     = {offset_i, 3'b000};
        lane_mask = 64'h0000_0000_0000_00FF;
      end
      SZ_H: begin
        shamt     = {offset_i[2:1], 4'b0000};
        lane_mask = 64'h0000_0000_0000_FFFF;
      end
      SZ_W: begin
        shamt     = {offset_i[2], 5'b00000};
        lane_mask = 64'h0000_0000_FFFF_FFFF;
      end
      SZ_D: begin
        shamt     = '0;
        lane_mask = '1;
      end
    endcase

    shifted = rdata_i >> shamt;

    unique case (mem_size_e'(size_i))
      SZ_B: sign_bit = shifted[7];
      SZ_H: sign_bit = shifted[15];
      SZ_W: sign_bit = shifted[31];
      SZ_D: sign_bit = 1'b0;
    endcase

    load_data_o = shifted & lane_mask;
    if (sign_ext_i && sign_bit) begin
      load_data_o = load_data_o | ~lane_mask;
    end

    merged_o = (rdata_i & ~(lane_mask << shamt)) | ((wdata_i & lane_mask) << shamt);
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage between EX/MEM and a dword-wide DataMemory.
//   clk, reset         : clock, synchronous active-high reset
//   in_*               : EX/MEM op (valid/ready handshake, flush drops the presented op)
//   dm_*               : DataMemory port; sub-word stores run as read then write (RMW)
//   wb_*               : registered MEM/WB entry, wb_valid pulses once per completed op
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned REG_IDX_W   = 5,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_flush,
  input  logic                 in_is_load,
  input  logic                 in_is_store,
  input  logic [1:0]           in_size,
  input  logic                 in_sign_ext,
  input  logic [63:0]          in_addr,
  input  logic [63:0]          in_wdata,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_reg_write,
  output logic                 dm_we,
  output logic [63:0]          dm_addr,
  output logic [63:0]          dm_wdata,
  input  logic [63:0]          dm_rdata,
  input  logic                 dm_err,
  output logic                 wb_valid,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic                 wb_reg_write,
  output logic [63:0]          wb_data,
  output logic                 wb_exc_misalign,
  output logic                 wb_exc_bus
);

  mem_state_e           state_q, state_d;
  logic [63:3]          addr_q, addr_d;
  logic [63:0]          merged_q, merged_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;

  logic                 wb_valid_q, wb_valid_d;
  logic [REG_IDX_W-1:0] wb_rd_q, wb_rd_d;
  logic                 wb_reg_write_q, wb_reg_write_d;
  logic [63:0]          wb_data_q, wb_data_d;
  logic                 wb_exc_misalign_q, wb_exc_misalign_d;
  logic                 wb_exc_bus_q, wb_exc_bus_d;

  logic        dm_we_raw;
  logic [63:0] load_data;
  logic [63:0] merged;
  mem_size_e   size;
  logic        is_mem;
  logic        misalign;
  logic        accept;

  assign size     = mem_size_e'(in_size);
  assign is_mem   = in_is_load | in_is_store;
  assign misalign = CHECK_ALIGN && is_mem && !aligned(in_addr[2:0], size);
  assign accept   = (state_q == IDLE) && in_valid && !in_flush;

  mem_lane_align u_lane (
    .rdata_i     (dm_rdata),
    .wdata_i     (in_wdata),
    .size_i      (in_size),
    .offset_i    (in_addr[2:0]),
    .sign_ext_i  (in_sign_ext),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    merged_d          = merged_q;
    rd_d              = rd_q;
    wb_valid_d        = 1'b0;
    wb_rd_d           = wb_rd_q;
    wb_reg_write_d    = wb_reg_write_q;
    wb_data_d         = wb_data_q;
    wb_exc_misalign_d = wb_exc_misalign_q;
    wb_exc_bus_d      = wb_exc_bus_q;
    dm_we_raw         = 1'b0;
    dm_addr           = {in_addr[63:3], 3'b000};
    dm_wdata          = in_wdata;
    in_ready          = (state_q == IDLE);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wb_valid_d        = 1'b1;
            wb_rd_d           = in_rd;
            wb_data_d         = in_addr;
            wb_reg_write_d    = in_reg_write;
            wb_exc_misalign_d = 1'b0;
            wb_exc_bus_d      = 1'b0;
          end else if (misalign || in_is_load || size == SZ_D || dm_err) begin
            // Every single-cycle memory outcome retires at the next edge.
            wb_valid_d        = 1'b1;
            wb_rd_d           = in_rd;
            wb_reg_write_d    = 1'b0;
            wb_exc_misalign_d = misalign;
            wb_exc_bus_d      = 1'b0;
            if (misalign) begin
              wb_exc_misalign_d = 1'b1;
            end else if (in_is_load) begin
              if (dm_err) begin
                wb_exc_bus_d = 1'b1;
              end else begin
                wb_data_d      = load_data;
                wb_reg_write_d = in_reg_write;
              end
            end else if (size == SZ_D) begin
              dm_we_raw = 1'b1;
            end else begin
              // Sub-word store whose read failed: abort before any write.
              wb_exc_bus_d = 1'b1;
            end
          end else begin
            merged_d = merged;
            addr_d   = in_addr[63:3];
            rd_d     = in_rd;
            state_d  = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        dm_we_raw         = 1'b1;
        dm_addr           = {addr_q, 3'b000};
        dm_wdata          = merged_q;
        wb_valid_d        = 1'b1;
        wb_rd_d           = rd_q;
        wb_reg_write_d    = 1'b0;
        wb_exc_misalign_d = 1'b0;
        wb_exc_bus_d      = 1'b0;
        state_d           = IDLE;
      end
    endcase
  end

  // A pending RMW write is dropped if reset lands in its write cycle.
  assign dm_we = dm_we_raw & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      addr_q            <= '0;
      merged_q          <= '0;
      rd_q              <= '0;
      wb_valid_q        <= 1'b0;
      wb_rd_q           <= '0;
      wb_reg_write_q    <= 1'b0;
      wb_data_q         <= '0;
      wb_exc_misalign_q <= 1'b0;
      wb_exc_bus_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      merged_q          <= merged_d;
      rd_q              <= rd_d;
      wb_valid_q        <= wb_valid_d;
      wb_rd_q           <= wb_rd_d;
      wb_reg_write_q    <= wb_reg_write_d;
      wb_data_q         <= wb_data_d;
      wb_exc_misalign_q <= wb_exc_misalign_d;
      wb_exc_bus_q      <= wb_exc_bus_d;
    end
  end

  assign wb_valid        = wb_valid_q;
  assign wb_rd           = wb_rd_q;
  assign wb_reg_write    = wb_reg_write_q;
  assign wb_data         = wb_data_q;
  assign wb_exc_misalign = wb_exc_misalign_q;
  assign wb_exc_bus      = wb_exc_bus_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios followed by random ops, checked against a
// byte-addressed reference memory and an in-order queue of expected MEM/WB entries.
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, in_flush, in_is_load, in_is_store, in_sign_ext;
  logic [1:0]  in_size;
  logic [63:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        dm_we, dm_err;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic        wb_valid, wb_reg_write, wb_exc_misalign, wb_exc_bus;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  mem_access_stage #(
    .REG_IDX_W   (5),
    .CHECK_ALIGN (1'b1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_flush        (in_flush),
    .in_is_load      (in_is_load),
    .in_is_store     (in_is_store),
    .in_size         (in_size),
    .in_sign_ext     (in_sign_ext),
    .in_addr         (in_addr),
    .in_wdata        (in_wdata),
    .in_rd           (in_rd),
    .in_reg_write    (in_reg_write),
    .dm_we           (dm_we),
    .dm_addr         (dm_addr),
    .dm_wdata        (dm_wdata),
    .dm_rdata        (dm_rdata),
    .dm_err          (dm_err),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .wb_reg_write    (wb_reg_write),
    .wb_data         (wb_data),
    .wb_exc_misalign (wb_exc_misalign),
    .wb_exc_bus      (wb_exc_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMemory stand-in: 64 dwords, combinational read, write on the clock edge.
  logic [63:0] dmem [0:63] = '{default: '0};
  assign dm_rdata = dmem[dm_addr[8:3]];

  int          we_cnt = 0;
  logic [63:0] last_wdata = '0;
  always @(posedge clk) begin
    if (dm_we) begin
      dmem[dm_addr[8:3]] <= dm_wdata;
      we_cnt     <= we_cnt + 1;
      last_wdata <= dm_wdata;
    end
  end

  // Reference model state.
  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        regw;
    logic        mis;
    logic        bus;
  } exp_t;

  logic [7:0]  rmem [0:511] = '{default: '0};
  exp_t        exp_q [$];
  logic [63:0] model_data = '0;
  logic [63:0] mon_data = '0;
  logic        mon_en = 1'b0;
  exp_t        mon_e;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Retirement checker, sampled 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_wb_valid", {63'b0, wb_valid}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wb_data", wb_data, mon_e.data);
          chk("wb_rd", {59'b0, wb_rd}, {59'b0, mon_e.rd});
          chk("wb_reg_write", {63'b0, wb_reg_write}, {63'b0, mon_e.regw});
          chk("wb_exc_misalign", {63'b0, wb_exc_misalign}, {63'b0, mon_e.mis});
          chk("wb_exc_bus", {63'b0, wb_exc_bus}, {63'b0, mon_e.bus});
          mon_data = mon_e.data;
        end
      end else begin
        chk("wb_data_hold", wb_data, mon_data);
      end
    end
  end

  task automatic idle(int n);
    in_valid = 1'b0;
    in_flush = 1'b0;
    dm_err   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Present one op (entered at a falling edge), wait for in_ready, record its expected outcome.
  task automatic send(bit ld, bit st, logic [1:0] sz, bit sx, logic [63:0] a, logic [63:0] wd,
                      logic [4:0] rd, bit rw, bit fl, bit er);
    int   guard;
    int   n;
    exp_t e;
    logic [63:0] v;
    guard = 0;
    while (!in_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", {63'b0, in_ready}, 64'd1);
    in_valid = 1'b1;  in_flush = fl;  in_is_load = ld;  in_is_store = st;
    in_size = sz;     in_sign_ext = sx; in_addr = a;    in_wdata = wd;
    in_rd = rd;       in_reg_write = rw; dm_err = er;
    if (!fl) begin
      n      = 1 << sz;
      e.rd   = rd;
      e.regw = 1'b0;
      e.bus  = 1'b0;
      e.data = model_data;
      e.mis  = (ld || st) && (int'(a[8:0]) % n != 0);
      if (!ld && !st) begin
        e.data = a;
        e.regw = rw;
      end else if (e.mis) begin
        // nothing touches memory
      end else if (ld) begin
        if (er) begin
          e.bus = 1'b1;
        end else begin
          v = '0;
          for (int i = 0; i < n; i++) v[8*i +: 8] = rmem[int'(a[8:0]) + i];
          if (sx && n < 8 && rmem[int'(a[8:0]) + n - 1][7]) begin
            for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
          end
          e.data = v;
          e.regw = rw;
        end
      end else if (er && n < 8) begin
        e.bus = 1'b1;
      end else begin
        for (int i = 0; i < n; i++) rmem[int'(a[8:0]) + i] = wd[8*i +: 8];
      end
      model_data = e.data;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin
    int          w0;
    int          kind;
    logic [1:0]  sz;
    logic [63:0] a;
    logic [63:0] exp_dw;

    reset = 1'b1;
    in_valid = 1'b0; in_flush = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    in_size = 2'd0;  in_sign_ext = 1'b0; in_addr = '0; in_wdata = '0;
    in_rd = '0;      in_reg_write = 1'b0; dm_err = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_wb_valid", {63'b0, wb_valid}, 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_wb_reg_write", {63'b0, wb_reg_write}, 64'd0);
    chk("rst_dm_we", {63'b0, dm_we}, 64'd0);
    mon_en = 1'b1;

    // Pass-through
    send(0, 0, 2'd0, 0, 64'h1234, 64'h0, 5'd3, 1, 0, 0);
    // Preload Mem[0x100], then byte loads at 0x107 with sign and zero extension
    send(0, 1, 2'd3, 0, 64'h100, 64'h8877665544332211, 5'd0, 0, 0, 0);
    send(1, 0, 2'd0, 1, 64'h107, 64'h0, 5'd4, 1, 0, 0);
    send(1, 0, 2'd0, 0, 64'h107, 64'h0, 5'd5, 1, 0, 0);
    idle(2);

    // Half store via RMW
    w0 = we_cnt;
    send(0, 1, 2'd1, 0, 64'h102, 64'hBEEF, 5'd0, 0, 0, 0);
    chk("rmw_in_ready_low", {63'b0, in_ready}, 64'd0);
    idle(2);
    chk("rmw_we_pulses", 64'(we_cnt - w0), 64'd1);
    chk("rmw_wdata", last_wdata, 64'h88776655BEEF2211);

    // Misaligned dword store
    w0 = we_cnt;
    send(0, 1, 2'd3, 0, 64'h104, 64'hDEAD, 5'd0, 0, 0, 0);
    idle(2);
    chk("misalign_no_write", 64'(we_cnt - w0), 64'd0);

    // Sub-word store whose read reports a bus error
    w0 = we_cnt;
    send(0, 1, 2'd1, 0, 64'h10A, 64'h5555, 5'd0, 0, 0, 1);
    idle(2);
    chk("buserr_no_write", 64'(we_cnt - w0), 64'd0);

    // Reset in the RMW write cycle abandons the write
    in_valid = 1'b1; in_flush = 1'b0; in_is_load = 1'b0; in_is_store = 1'b1;
    in_size = 2'd0;  in_addr = 64'h110; in_wdata = 64'hA5; dm_err = 1'b0;
    @(negedge clk);
    chk("rst_rmw_state", {63'b0, in_ready}, 64'd0);
    mon_en = 1'b0;
    w0 = we_cnt;
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_rmw_no_write", 64'(we_cnt - w0), 64'd0);
    chk("rst_rmw_idle", {63'b0, in_ready}, 64'd1);
    chk("rst_rmw_wb_valid", {63'b0, wb_valid}, 64'd0);
    model_data = '0;
    mon_data = '0;
    mon_en = 1'b1;

    // Back-to-back load, store word, load of the stored word
    send(1, 0, 2'd2, 1, 64'h108, 64'h0, 5'd6, 1, 0, 0);
    send(0, 1, 2'd2, 0, 64'h10C, 64'hCAFEF00D, 5'd0, 0, 0, 0);
    send(1, 0, 2'd2, 0, 64'h10C, 64'h0, 5'd7, 1, 0, 0);
    idle(2);

    // Random mix
    for (int k = 0; k < 300; k++) begin
      kind = int'($urandom_range(0, 9));
      sz   = 2'($urandom_range(0, 3));
      a    = 64'($urandom_range(0, 511));
      if ($urandom_range(0, 9) < 7) a = a & ~64'((1 << sz) - 1);
      if (kind < 2) begin
        send(0, 0, sz, 0, {$urandom, $urandom}, 64'h0, 5'($urandom), 1'($urandom), 
             ($urandom_range(0, 9) == 0), 0);
      end else begin
        send(kind < 6, kind >= 6, sz, 1'($urandom), a, {$urandom, $urandom}, 5'($urandom),
             1'($urandom), ($urandom_range(0, 9) == 0),
             (sz != 2'd3 || kind < 6) && ($urandom_range(0, 7) == 0));
      end
      if ($urandom_range(0, 5) == 0) idle(1);
    end
    idle(4);

    chk("pending_ops", 64'(exp_q.size()), 64'd0);
    for (int d = 0; d < 64; d++) begin
      for (int i = 0; i < 8; i++) exp_dw[8*i +: 8] = rmem[d*8 + i];
      chk("final_mem", dmem[d], exp_dw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
